// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one Avalon-style memory port; registered grant FSM, round-robin, bounded bursts.
// Latency: 1 cycle from a request in IDLE to slave presentation; zero-gap handover at the burst limit.
// Backpressure: the owner sees s_waitrequest, the other master is held at waitrequest=1. ARB_FIXED_PRIO_EN selects m0-priority mode.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    output logic [1:0]          grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [4:0] cnt_inc;
    logic [3:0] cnt_sat;
    logic       at_limit;
    logic       req0, req1;
    logic       rr_pick_m1;
    logic       gnt0_limited;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign cnt_inc  = {1'b0, cnt} + 5'd1;
    assign at_limit = (cnt_inc >= 5'(BURST_MAX));
    assign cnt_sat  = at_limit ? 4'(BURST_MAX) : cnt_inc[3:0];

`ifdef ARB_FIXED_PRIO_EN
    // m0 wins every contention and is never forced off the bus
    assign rr_pick_m1   = 1'b0;
    assign gnt0_limited = 1'b0;
`else
    logic prio, prio_nxt;

    // prio remembers the master that last released the bus
    always_comb begin
        prio_nxt = prio;
        if (state == GNT0 && state_nxt != GNT0)
            prio_nxt = 1'b0;
        else if (state == GNT1 && state_nxt != GNT1)
            prio_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prio <= 1'b1;
        else
            prio <= prio_nxt;
    end

    assign rr_pick_m1   = ~prio;
    assign gnt0_limited = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = 4'd0;
                if (req0 && (!req1 || !rr_pick_m1))
                    state_nxt = GNT0;
                else if (req1)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (!req0) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = req1 ? GNT1 : IDLE;
                end else if (!s_waitrequest) begin
                    if (gnt0_limited && at_limit && req1) begin
                        cnt_nxt   = 4'd0;
                        state_nxt = GNT1;
                    end else begin
                        cnt_nxt = cnt_sat;
                    end
                end
            end
            GNT1: begin
                if (!req1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = req0 ? GNT0 : IDLE;
                end else if (!s_waitrequest) begin
                    if (at_limit && req0) begin
                        cnt_nxt   = 4'd0;
                        state_nxt = GNT0;
                    end else begin
                        cnt_nxt = cnt_sat;
                    end
                end
            end
            default: begin
                cnt_nxt   = 4'd0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Slave side and stalls depend only on the registered owner, so reset drops strobes at once
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        grant          = 2'b00;
        case (state)
            GNT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                grant          = 2'b01;
            end
            GNT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                grant          = 2'b10;
            end
            default: ;
        endcase
    end

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter that shares the single Avalon-style memory port (address/read/write/waitrequest/byteenable/readdata) between two masters.
- Master 0 is the CPU bus interface; master 1 is a secondary master such as a program loader or DMA.
- Sits between the masters and the memory model/RAM.
- Sequences ownership with a registered grant FSM, round-robin fairness and a bounded back-to-back burst length.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- BURST_MAX, 4, max consecutive completed transactions a master may keep while the other waits (1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m0_address / m1_address  in  ADDR_W  master address.
- m0_read / m1_read  in  1  read strobe.
- m0_write / m1_write  in  1  write strobe.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes.
- m0_waitrequest / m1_waitrequest  out  1  stall to master.
- m0_readdata / m1_readdata  out  DATA_W  read data to master.
- s_address  out  ADDR_W  to memory.
- s_read, s_write  out  1  to memory.
- s_writedata  out  DATA_W  to memory.
- s_byteenable  out  DATA_W/8  to memory.
- s_waitrequest  in  1  memory stall.
- s_readdata  in  DATA_W  memory read data.
- grant  out  2  one-hot current owner; 00 = idle.

Behaviour:
- Request: mk_req = mk_read | mk_write. Masters hold all signals stable while their waitrequest = 1. read & write together is illegal and is forwarded unchanged.
- States: IDLE, GNT0, GNT1. State, prio (last-served master), cnt (4-bit) are registered. All outputs are combinational from state.
- Reset (reset=0, asynchronous):
  - state = IDLE, prio = 1 (m0 favoured first), cnt = 0.
  - s_read = s_write = 0; s_address, s_writedata, s_byteenable = 0.
  - m0_waitrequest = m1_waitrequest = 1; grant = 00.
  - Reset asserted mid-transaction drops s_read/s_write immediately; no completion is signalled.
- IDLE:
  - Slave strobes 0, slave data outputs 0, both waitrequests 1.
  - Next state: only m0_req -> GNT0; only m1_req -> GNT1; both -> the master != prio; none -> IDLE.
  - Arbitration latency is 1 cycle: a request seen in IDLE is presented to the slave the following cycle.
- GNTk:
  - s_* = mk_*; mk_waitrequest = s_waitrequest; other master's waitrequest = 1; grant bit k = 1.
  - Both mX_readdata = s_readdata; only the granted master's copy is meaningful.
- Completion: mk_req & !s_waitrequest in GNTk. On completion cnt <= cnt+1, saturating at BURST_MAX.
- Handover:
  - Completion with cnt+1 >= BURST_MAX and other master requesting -> GNT(other), cnt <= 0, prio <= k. Zero-gap switch.
  - Any other completion -> stay GNTk.
  - mk_req = 0 in GNTk -> GNT(other) if other requesting, else IDLE; cnt <= 0, prio <= k.
  - The grant never changes while s_waitrequest = 1 with mk_req = 1; a stalled transaction is never broken.
- Entering GNTk from IDLE sets cnt <= 0.
- Master k may issue back-to-back accesses with a new address in the cycle after completion without losing the grant, unless the burst limit applies.

Optional Feature:
- ARB_FIXED_PRIO_EN defined:
  - On contention in IDLE, m0 always wins.
  - In GNT0, BURST_MAX is ignored: m0 keeps the bus until it deasserts req.
  - GNT1 still hands over to m0 after BURST_MAX completions.
  - prio register is unused.
- Undefined: round-robin with burst limit as above.

Test Plan:
- Reset then m0_read=1, addr=0xBFC00000, s_waitrequest=0:
  - cycle 1: m0_waitrequest=1, s_read=0.
  - cycle 2: s_address=0xBFC00000, s_read=1, grant=01, m0_waitrequest=0, m0_readdata=s_readdata.
- m0 read stalled with s_waitrequest=1 for 3 cycles while m1_write=1:
  - grant stays 01 and m1_waitrequest=1 throughout.
  - grant=01 in the completion cycle; m1_waitrequest stays 1 in that cycle.
  - grant moves to 10 the cycle after completion.
- Both masters requesting continuously, s_waitrequest=0, BURST_MAX=4:
  - grants alternate 4×m0, 4×m1, 4×m0 with no idle cycles between bursts.
- m1 alone issues 10 back-to-back writes (0x1000..0x1024):
  - grant stays 10, all 10 writes complete in 10 cycles after the first grant.
  - m1 drops req -> IDLE next cycle.
- reset driven low while GNT1 with s_write=1:
  - s_write=0, grant=00 in the same cycle.
  - After release, simultaneous m0/m1 requests -> GNT0 first.
- ARB_FIXED_PRIO_EN, both requesting continuously:
  - m0 holds grant for all 20 transactions; m1 is served only after m0 deasserts.
